// File: rtl/txpy_pkg.sv
// txpy_pkg: shared definitions for the TX payload buffer fetch block.
//   txpy_state_e : fetch FSM states (IDLE, FILL, RUN, DONE)
//   WORD_W       : SRAM payload word width
//   NWORDS_W     : width of the payload word count (0..256)
//   calc_nwords  : number of 32-bit words covering a bit length
package txpy_pkg;

  localparam int WORD_W   = 32;
  localparam int NWORDS_W = 9;
  localparam int BITPTR_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } txpy_state_e;

  // Round the bit length up to whole words; 8191 bits needs 14 bits before the shift.
  function automatic logic [NWORDS_W-1:0] calc_nwords(input logic [12:0] len);
    return NWORDS_W'(({1'b0, len} + 14'd31) >> 5);
  endfunction

endpackage

// File: rtl/txpybuf_pingpong.sv
// txpybuf_pingpong: two 32-bit payload slots with valid bits and an LSB-first
// bit serializer that walks the current slot and then hands over to the other.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_clr          : restart (payload start); empties both slots, rewinds serializer
//   i_take         : consumer took the current bit (already gated to FILL/RUN)
//   i_wr_en        : load i_wr_data into slot i_wr_slot and mark it valid
//   o_bit          : current payload bit, 0 while the current slot is empty
//   o_ready        : current slot holds a valid word
//   o_slot_vld     : per-slot valid bits, used by the prefetcher
module txpybuf_pingpong
  import txpy_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_take,
  input  logic              i_wr_en,
  input  logic              i_wr_slot,
  input  logic [WORD_W-1:0] i_wr_data,
  output logic              o_bit,
  output logic              o_ready,
  output logic [1:0]        o_slot_vld
);

  logic [WORD_W-1:0]   r_slot [2];
  logic [1:0]          r_vld;
  logic                r_cur;
  logic [BITPTR_W-1:0] r_bitptr;
  logic                w_ready;
  logic                w_wrap;

  assign w_ready = r_vld[r_cur];
  // A slot is only released after its last bit was taken while it was valid;
  // takes during a stall advance the pointer but never skip a word.
  assign w_wrap  = i_take && w_ready && (r_bitptr == '1);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_vld    <= 2'b00;
      r_cur    <= 1'b0;
      r_bitptr <= '0;
    end else begin
      if (i_take) r_bitptr <= r_bitptr + 1'b1;
      if (w_wrap) begin
        r_vld[r_cur] <= 1'b0;
        r_cur        <= ~r_cur;
      end
      // The written slot is always an empty one, so it never collides with the freed slot.
      if (i_wr_en) r_vld[i_wr_slot] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_slot[i_wr_slot] <= i_wr_data;
  end

  assign o_bit      = w_ready & r_slot[r_cur][r_bitptr];
  assign o_ready    = w_ready;
  assign o_slot_vld = r_vld;

endmodule

// File: rtl/txpybuf_fetch.sv
// txpybuf_fetch: TX payload source for pybitp. Prefetches 32-bit payload words
// from the TX payload SRAM into a two-slot ping-pong buffer and presents them
// LSB-first on bufpacketin, one bit per consumer take.
// Ports:
//   clk_6M, rst        : clock, synchronous active-high reset
//   py_st_p            : payload start; samples pylenbit/base_adr and restarts
//   bit_take_p         : consumer took the current bit
//   rd_req/rd_adr      : SRAM read request (held until ack) and word address
//   rd_ack/rd_data     : SRAM ack with data in the same cycle
//   bufpacketin        : current payload bit
//   buf_ready          : current word valid
//   underrun           : sticky consumer-outran-SRAM flag
//   fetch_done         : all payload words fetched
// Build option: define TXPYBUF_UNDERRUN_CNT_EN to add underrun_cnt[7:0], a
// saturating count of bit takes made while no word was ready.
module txpybuf_fetch
  import txpy_pkg::*;
#(
  parameter int ADR_W      = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk_6M,
  input  logic              rst,
  input  logic              py_st_p,
  input  logic [12:0]       pylenbit,
  input  logic [ADR_W-1:0]  base_adr,
  input  logic              bit_take_p,
  output logic              rd_req,
  output logic [ADR_W-1:0]  rd_adr,
  input  logic              rd_ack,
  input  logic [WORD_W-1:0] rd_data,
  output logic              bufpacketin,
  output logic              buf_ready,
  output logic              underrun,
  output logic              fetch_done
`ifdef TXPYBUF_UNDERRUN_CNT_EN
  ,
  output logic [7:0]        underrun_cnt
`endif
);

  localparam int TO_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(RD_TIMEOUT);

  txpy_state_e         r_state;
  logic [NWORDS_W-1:0] r_nwords;
  logic [NWORDS_W-1:0] r_fetched;
  logic [ADR_W-1:0]    r_base;
  logic                r_rd_req;
  logic [ADR_W-1:0]    r_rd_adr;
  // Set when a restart abandoned an outstanding request: the next ack belongs
  // to the previous epoch and is swallowed instead of loaded.
  logic                r_stale;
  logic [TO_W-1:0]     r_wait;
  logic                r_wr_slot;
  logic                r_underrun;
  logic                r_fetch_done;

  logic [NWORDS_W-1:0] w_nwords;
  logic                w_active;
  logic                w_take;
  logic                w_under_take;
  logic                w_wr_en;
  logic                w_issue;
  logic                w_bit;
  logic                w_ready;
  logic [1:0]          w_slot_vld;

  assign w_nwords     = calc_nwords(pylenbit);
  assign w_active     = (r_state == FILL) || (r_state == RUN);
  assign w_take       = bit_take_p && w_active;
  assign w_under_take = w_take && !w_ready;
  assign w_wr_en      = r_rd_req && rd_ack && !py_st_p;
  // Slots fill and drain in the same 0,1,0,1 order, so the next word always
  // targets r_wr_slot; one request in flight at a time.
  assign w_issue      = w_active && !r_rd_req && !r_stale &&
                        (r_fetched < r_nwords) && !w_slot_vld[r_wr_slot];

  txpybuf_pingpong u_pingpong (
    .i_clk      (clk_6M),
    .i_rst      (rst),
    .i_clr      (py_st_p),
    .i_take     (w_take),
    .i_wr_en    (w_wr_en),
    .i_wr_slot  (r_wr_slot),
    .i_wr_data  (rd_data),
    .o_bit      (w_bit),
    .o_ready    (w_ready),
    .o_slot_vld (w_slot_vld)
  );

  always_ff @(posedge clk_6M) begin
    if (rst) begin
      r_state      <= IDLE;
      r_nwords     <= '0;
      r_fetched    <= '0;
      r_rd_req     <= 1'b0;
      r_rd_adr     <= '0;
      r_stale      <= 1'b0;
      r_wait       <= '0;
      r_wr_slot    <= 1'b0;
      r_underrun   <= 1'b0;
      r_fetch_done <= 1'b0;
    end else if (py_st_p) begin
      r_nwords     <= w_nwords;
      r_base       <= base_adr;
      r_fetched    <= '0;
      r_rd_req     <= 1'b0;
      r_stale      <= (r_rd_req || r_stale) && !rd_ack;
      r_wait       <= '0;
      r_wr_slot    <= 1'b0;
      r_underrun   <= 1'b0;
      r_fetch_done <= (w_nwords == '0);
      r_state      <= (w_nwords == '0) ? DONE : FILL;
    end else begin
      if (r_stale) begin
        // Give up on the abandoned ack after the timeout so a silent SRAM cannot wedge FILL.
        if (rd_ack || (r_wait == TO_MAX)) begin
          r_stale <= 1'b0;
          r_wait  <= '0;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
      end else if (r_rd_req) begin
        if (rd_ack) begin
          r_rd_req  <= 1'b0;
          r_wait    <= '0;
          r_fetched <= r_fetched + 1'b1;
          r_wr_slot <= ~r_wr_slot;
          if ((r_fetched + 1'b1) == r_nwords) r_fetch_done <= 1'b1;
          if (r_state == FILL) r_state <= RUN;
        end else if (r_wait == TO_MAX) begin
          r_underrun <= 1'b1;
        end else begin
          r_wait <= r_wait + 1'b1;
        end
      end else if (w_issue) begin
        r_rd_req <= 1'b1;
        r_rd_adr <= r_base + ADR_W'(r_fetched);
        r_wait   <= '0;
      end

      if (w_under_take) r_underrun <= 1'b1;

      if ((r_state == RUN) && r_fetch_done && (w_slot_vld == 2'b00) && !r_rd_req)
        r_state <= DONE;
    end
  end

`ifdef TXPYBUF_UNDERRUN_CNT_EN
  logic [7:0] r_ucnt;

  always_ff @(posedge clk_6M) begin
    if (rst || py_st_p) begin
      r_ucnt <= 8'd0;
    end else if (w_under_take && (r_ucnt != 8'hFF)) begin
      r_ucnt <= r_ucnt + 8'd1;
    end
  end

  assign underrun_cnt = r_ucnt;
`endif

  assign rd_req      = r_rd_req;
  assign rd_adr      = r_rd_adr;
  assign bufpacketin = w_bit;
  assign buf_ready   = w_ready;
  assign underrun    = r_underrun;
  assign fetch_done  = r_fetch_done;

endmodule

// File: tb/tb_txpybuf_fetch.sv
// Testbench for txpybuf_fetch: directed scenarios with an SRAM responder,
// expected bits/addresses queued by the stimulus and checked by a monitor.
module tb_txpybuf_fetch;

  localparam int ADR_W = 8;

  logic        clk_6M = 1'b0;
  logic        rst;
  logic        py_st_p;
  logic [12:0] pylenbit;
  logic [7:0]  base_adr;
  logic        bit_take_p;
  logic        rd_req;
  logic [7:0]  rd_adr;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic        bufpacketin;
  logic        buf_ready;
  logic        underrun;
  logic        fetch_done;
`ifdef TXPYBUF_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  always #5 clk_6M = ~clk_6M;

  txpybuf_fetch #(.ADR_W(ADR_W), .RD_TIMEOUT(15)) dut (
    .clk_6M      (clk_6M),
    .rst         (rst),
    .py_st_p     (py_st_p),
    .pylenbit    (pylenbit),
    .base_adr    (base_adr),
    .bit_take_p  (bit_take_p),
    .rd_req      (rd_req),
    .rd_adr      (rd_adr),
    .rd_ack      (rd_ack),
    .rd_data     (rd_data),
    .bufpacketin (bufpacketin),
    .buf_ready   (buf_ready),
    .underrun    (underrun),
    .fetch_done  (fetch_done)
`ifdef TXPYBUF_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  bit         exp_bits[$];
  logic [7:0] exp_adr[$];
  logic [31:0] mem [256];
  int         ack_dly  = 2;
  int         slow_at  = -1;
  int         slow_dly = 0;
  int         req_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start(input logic [12:0] len, input logic [7:0] base);
    pylenbit = len;
    base_adr = base;
    py_st_p  = 1'b1;
    tick();
    py_st_p  = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_bits.push_back(w[i]);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!buf_ready && n < 400) begin
      tick();
      n++;
    end
    if (!buf_ready) chk({name, "_ready_timeout"}, 0, 1);
  endtask

  task automatic take_n(input int n, input int gap, input string name);
    for (int i = 0; i < n; i++) begin
      wait_ready(name);
      bit_take_p = 1'b1;
      tick();
      bit_take_p = 1'b0;
      if (gap > 1) ticks(gap - 1);
    end
  endtask

  task automatic drain_check(input string name);
    chk({name, "_bits_left"}, 32'(exp_bits.size()), 0);
    chk({name, "_adrs_left"}, 32'(exp_adr.size()), 0);
    exp_bits.delete();
    exp_adr.delete();
  endtask

  // SRAM responder: latches each new request and acks it after its delay,
  // even if the request was withdrawn in the meantime.
  initial begin
    logic [7:0] a;
    int         d;
    rd_ack  = 1'b0;
    rd_data = '0;
    forever begin
      @(posedge clk_6M);
      #1;
      if (rd_req) begin
        a = rd_adr;
        d = (req_seen == slow_at) ? slow_dly : ack_dly;
        req_seen++;
        for (int k = 0; k < d - 1; k++) @(posedge clk_6M);
        #1;
        rd_ack  = 1'b1;
        rd_data = mem[a];
        @(posedge clk_6M);
        #1;
        rd_ack  = 1'b0;
      end
    end
  end

  // Monitor: every valid take pops an expected bit, every new request pops an expected address.
  initial begin
    bit         prev_req;
    bit         eb;
    logic [7:0] ea;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_6M);
      if (!rst) begin
        if (bit_take_p && buf_ready) begin
          if (exp_bits.size() == 0) begin
            chk("bit_unexpected", 32'(bufpacketin), 32'hDEAD);
          end else begin
            eb = exp_bits.pop_front();
            chk("bit", 32'(bufpacketin), 32'(eb));
          end
        end
        if (rd_req && !prev_req) begin
          if (exp_adr.size() == 0) begin
            chk("adr_unexpected", 32'(rd_adr), 32'hDEAD);
          end else begin
            ea = exp_adr.pop_front();
            chk("rd_adr", 32'(rd_adr), 32'(ea));
          end
        end
      end
      prev_req = rd_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst        = 1'b1;
    py_st_p    = 1'b0;
    bit_take_p = 1'b0;
    pylenbit   = '0;
    base_adr   = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h9E37_79B9 * 32'(i + 1);
    mem[8'h10] = 32'hA5A5_0001;
    mem[8'h11] = 32'h0000_FFFF;
    mem[8'h30] = ~mem[8'h50];
    ticks(3);

    // Reset values
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_rd_adr", 32'(rd_adr), 0);
    chk("rst_bit", 32'(bufpacketin), 0);
    chk("rst_buf_ready", 32'(buf_ready), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_fetch_done", 32'(fetch_done), 0);
`ifdef TXPYBUF_UNDERRUN_CNT_EN
    chk("rst_ucnt", 32'(underrun_cnt), 0);
`endif
    rst = 1'b0;
    tick();

    // 64 bits from 0x10: two reads, all bits LSB-first, then DONE
    req_seen = 0;
    exp_adr.push_back(8'h10);
    exp_adr.push_back(8'h11);
    push_word(mem[8'h10], 0, 31);
    push_word(mem[8'h11], 0, 31);
    start(13'd64, 8'h10);
    take_n(64, 1, "s1");
    ticks(4);
    chk("s1_reads", 32'(req_seen), 2);
    chk("s1_fetch_done", 32'(fetch_done), 1);
    chk("s1_buf_ready", 32'(buf_ready), 0);
    chk("s1_bit", 32'(bufpacketin), 0);
    chk("s1_rd_req", 32'(rd_req), 0);
    bit_take_p = 1'b1;
    tick();
    bit_take_p = 1'b0;
    tick();
    chk("s1_done_take_underrun", 32'(underrun), 0);
    drain_check("s1");

    // 40 bits round up to 2 words; the tail of word 1 is still served
    req_seen = 0;
    exp_adr.push_back(8'h60);
    exp_adr.push_back(8'h61);
    push_word(mem[8'h60], 0, 31);
    push_word(mem[8'h61], 0, 31);
    start(13'd40, 8'h60);
    take_n(64, 1, "s2");
    ticks(4);
    chk("s2_reads", 32'(req_seen), 2);
    chk("s2_fetch_done", 32'(fetch_done), 1);
    drain_check("s2");

    // Zero-length payload
    req_seen = 0;
    start(13'd0, 8'h70);
    chk("s3_fetch_done", 32'(fetch_done), 1);
    chk("s3_buf_ready", 32'(buf_ready), 0);
    ticks(8);
    chk("s3_rd_req", 32'(rd_req), 0);
    chk("s3_reads", 32'(req_seen), 0);
    drain_check("s3");

    // Take during FILL: underrun, pointer still advances past bit 0
    ack_dly  = 4;
    req_seen = 0;
    exp_adr.push_back(8'h20);
    push_word(mem[8'h20], 1, 31);
    start(13'd32, 8'h20);
    chk("s4_not_ready", 32'(buf_ready), 0);
    bit_take_p = 1'b1;
    tick();
    bit_take_p = 1'b0;
    chk("s4_underrun", 32'(underrun), 1);
    take_n(31, 1, "s4");
    ticks(4);
    chk("s4_underrun_sticky", 32'(underrun), 1);
    chk("s4_fetch_done", 32'(fetch_done), 1);
`ifdef TXPYBUF_UNDERRUN_CNT_EN
    chk("s4_ucnt", 32'(underrun_cnt), 1);
`endif
    drain_check("s4");

    // Second read stalls far beyond the consumer; takes every 6 cycles
    ack_dly  = 2;
    req_seen = 0;
    slow_at  = 1;
    slow_dly = 230;
    exp_adr.push_back(8'h40);
    exp_adr.push_back(8'h41);
    push_word(mem[8'h40], 0, 31);
    start(13'd64, 8'h40);
    chk("s5_underrun_clr", 32'(underrun), 0);
    take_n(32, 6, "s5");
    for (int k = 0; k < 3; k++) begin
      chk("s5_stall_ready", 32'(buf_ready), 0);
      chk("s5_stall_bit", 32'(bufpacketin), 0);
      bit_take_p = 1'b1;
      tick();
      bit_take_p = 1'b0;
      ticks(5);
    end
    chk("s5_underrun", 32'(underrun), 1);
`ifdef TXPYBUF_UNDERRUN_CNT_EN
    chk("s5_ucnt", 32'(underrun_cnt), 3);
`endif
    wait_ready("s5_resume");
    push_word(mem[8'h41], 3, 3);
    bit_take_p = 1'b1;
    tick();
    bit_take_p = 1'b0;
    tick();
    slow_at = -1;
    // Reset mid-transfer
    rst = 1'b1;
    tick();
    chk("s5_rst_underrun", 32'(underrun), 0);
    chk("s5_rst_ready", 32'(buf_ready), 0);
    chk("s5_rst_fetch_done", 32'(fetch_done), 0);
    chk("s5_rst_rd_req", 32'(rd_req), 0);
    chk("s5_rst_bit", 32'(bufpacketin), 0);
    rst = 1'b0;
    tick();
    drain_check("s5");

    // Address wrap-around
    req_seen = 0;
    exp_adr.push_back(8'hFF);
    exp_adr.push_back(8'h00);
    exp_adr.push_back(8'h01);
    push_word(mem[8'hFF], 0, 31);
    push_word(mem[8'h00], 0, 31);
    push_word(mem[8'h01], 0, 31);
    start(13'd96, 8'hFF);
    take_n(96, 1, "s6");
    ticks(4);
    chk("s6_reads", 32'(req_seen), 3);
    chk("s6_fetch_done", 32'(fetch_done), 1);
    drain_check("s6");

    // Restart with a request outstanding; the late ack must not load
    ack_dly  = 8;
    req_seen = 0;
    exp_adr.push_back(8'h30);
    start(13'd32, 8'h30);
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    chk("s7_first_req", 32'(rd_req), 1);
    ticks(2);
    exp_adr.push_back(8'h50);
    push_word(mem[8'h50], 0, 31);
    start(13'd32, 8'h50);
    chk("s7_req_dropped", 32'(rd_req), 0);
    take_n(32, 1, "s7");
    ticks(4);
    chk("s7_reads", 32'(req_seen), 2);
    chk("s7_fetch_done", 32'(fetch_done), 1);
    chk("s7_underrun", 32'(underrun), 0);
    drain_check("s7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
